// File: rtl/cernbe_fifo_port_if.sv
// CERN-BE submap bus bundle between the upstream submap decoder (master)
// and a terminating port (slave).
//   VMEAddr   : word select, 0 = STATUS, 1 = DATA
//   VMERdMem  : one-cycle read strobe;   VMEWrMem : one-cycle write strobe
//   VMEWrData : write data, qualified by VMEWrMem
//   VMERdData : registered read data, valid while VMERdDone is high
//   VMERdDone / VMEWrDone : one-cycle completion pulses
interface cernbe_fifo_port_if;
  logic [2:2]  VMEAddr;
  logic [31:0] VMERdData;
  logic [31:0] VMEWrData;
  logic        VMERdMem;
  logic        VMEWrMem;
  logic        VMERdDone;
  logic        VMEWrDone;

  modport master (
    output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    input  VMERdData, VMERdDone, VMEWrDone
  );

  modport slave (
    input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    output VMERdData, VMERdDone, VMEWrDone
  );
endinterface

// File: rtl/cernbe_fifo_port.sv
// Streaming FIFO exposed to software through a two-word CERN-BE submap.
// A local producer pushes 32-bit words over valid/ready; the bus side reads
// STATUS, pops words from DATA, and may push words into DATA for loopback.
// Ports:
//   Clk, Rst        : clock, synchronous active-high reset
//   vme             : submap bus (slave side), see cernbe_fifo_port_if
//   fifo_wr_data_i  : producer word
//   fifo_wr_valid_i : producer word valid
//   fifo_wr_ready_o : word accepted this cycle when valid is also high
//   fifo_empty_o    : registered count == 0
//   fifo_full_o     : registered count == DEPTH
// STATUS word: [15:0] count, [16] empty, [17] full, [18] overflow sticky,
//              [19] underflow sticky. Writing STATUS: bit0 clears the FIFO,
//              bit1 clears both sticky bits.
module cernbe_fifo_port #(
  parameter int DEPTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  cernbe_fifo_port_if.slave    vme,
  input  logic [31:0]          fifo_wr_data_i,
  input  logic                 fifo_wr_valid_i,
  output logic                 fifo_wr_ready_o,
  output logic                 fifo_empty_o,
  output logic                 fifo_full_o
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          ovf, udf;
  logic [31:0]   rd_data;
  logic          rd_done, wr_done;

  logic          sel_data, wr_stb, rd_stb;
  logic          clr, clr_sticky, bus_push_req, pop_req;
  logic          empty, full, ready;
  logic          stream_push, bus_push, push, pop;
  logic [31:0]   push_data, status;

  // A strobe with both read and write high is treated as a write only;
  // the read still gets its done pulse with the previous read data.
  assign sel_data     = vme.VMEAddr[2];
  assign wr_stb       = vme.VMEWrMem;
  assign rd_stb       = vme.VMERdMem && !vme.VMEWrMem;

  assign clr          = wr_stb && !sel_data && vme.VMEWrData[0];
  assign clr_sticky   = wr_stb && !sel_data && vme.VMEWrData[1];
  assign bus_push_req = wr_stb && sel_data;
  assign pop_req      = rd_stb && sel_data;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);

  // Bus DATA writes own the write port, and a clear must not race a push,
  // so the stream is held off in either case.
  assign ready        = !full && !Rst && !(wr_stb && (sel_data || vme.VMEWrData[0]));
  assign stream_push  = fifo_wr_valid_i && ready;
  assign bus_push     = bus_push_req && !full;
  assign push         = stream_push || bus_push;
  assign pop          = pop_req && !empty;
  assign push_data    = bus_push ? vme.VMEWrData : fifo_wr_data_i;

  assign status       = {12'd0, udf, ovf, full, empty, 16'(count)};

  // Storage is never reset; a clear only rewinds the pointers.
  always_ff @(posedge Clk) begin
    if (!Rst && push && !clr)
      mem[tail] <= push_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      rd_data <= '0;
      rd_done <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      rd_done <= vme.VMERdMem;
      wr_done <= vme.VMEWrMem;

      if (clr) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        if (push && !pop)      count <= count + (AW+1)'(1);
        else if (pop && !push) count <= count - (AW+1)'(1);
      end

      if (clr_sticky) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (bus_push_req && full) ovf <= 1'b1;
        if (pop_req && empty)     udf <= 1'b1;
      end

      if (rd_stb)
        rd_data <= sel_data ? (empty ? 32'd0 : mem[head]) : status;
    end
  end

  assign vme.VMERdData = rd_data;
  assign vme.VMERdDone = rd_done;
  assign vme.VMEWrDone = wr_done;
  assign fifo_wr_ready_o = ready;
  assign fifo_empty_o    = empty;
  assign fifo_full_o     = full;
endmodule

// File: tb/tb_cernbe_fifo_port.sv
module tb_cernbe_fifo_port;
  localparam int DEPTH = 16;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] fifo_wr_data_i;
  logic        fifo_wr_valid_i;
  logic        fifo_wr_ready_o, fifo_empty_o, fifo_full_o;

  cernbe_fifo_port_if vif();

  cernbe_fifo_port #(.DEPTH(DEPTH)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .vme             (vif),
    .fifo_wr_data_i  (fifo_wr_data_i),
    .fifo_wr_valid_i (fifo_wr_valid_i),
    .fifo_wr_ready_o (fifo_wr_ready_o),
    .fifo_empty_o    (fifo_empty_o),
    .fifo_full_o     (fifo_full_o)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the FIFO contents as a plain queue plus sticky flags.
  logic [31:0] mq[$];
  bit          m_ovf, m_udf, m_valid, m_rst_prev;
  logic [31:0] m_last;

  typedef struct { logic [31:0] d; int due; } exp_t;
  exp_t rq[$];
  exp_t wq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int cnt;
    cnt = mq.size();
    return {12'd0, m_udf, m_ovf, cnt == DEPTH, cnt == 0, 16'(cnt)};
  endfunction

  // One bus/stream cycle: check registered state, drive, check ready,
  // then advance the model to what the next edge should produce.
  task automatic cycle(input bit rst, input bit rd, input bit wr, input bit addr,
                       input logic [31:0] wd, input bit sv, input logic [31:0] sd);
    bit exp_rdy;
    logic [31:0] e;
    int c;
    @(negedge Clk);
    if (m_valid) begin
      chk("empty", 32'(fifo_empty_o), 32'(mq.size() == 0));
      chk("full",  32'(fifo_full_o),  32'(mq.size() == DEPTH));
      if (m_rst_prev) begin
        chk("rst_rddata", vif.VMERdData, 32'd0);
        chk("rst_done",   {30'd0, vif.VMERdDone, vif.VMEWrDone}, 32'd0);
      end
    end
    Rst             = rst;
    vif.VMERdMem    = rd;
    vif.VMEWrMem    = wr;
    vif.VMEAddr     = addr;
    vif.VMEWrData   = wd;
    fifo_wr_valid_i = sv;
    fifo_wr_data_i  = sd;
    #1;
    exp_rdy = !rst && (mq.size() < DEPTH) && !(wr && (addr || wd[0]));
    chk("ready", 32'(fifo_wr_ready_o), 32'(exp_rdy));
    c = cyc;
    m_rst_prev = rst;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_last = '0; m_valid = 1;
      return;
    end
    if (wr) begin
      wq.push_back('{32'd0, c + 1});
      if (rd) rq.push_back('{m_last, c + 1});
      if (addr) begin
        if (mq.size() < DEPTH) mq.push_back(wd);
        else m_ovf = 1;
      end else begin
        if (wd[0]) mq.delete();
        if (wd[1]) begin m_ovf = 0; m_udf = 0; end
      end
    end else if (rd) begin
      if (addr) begin
        if (mq.size() > 0) e = mq.pop_front();
        else begin e = '0; m_udf = 1; end
      end else e = m_status();
      m_last = e;
      rq.push_back('{e, c + 1});
    end
    if (sv && exp_rdy) mq.push_back(sd);
  endtask

  // Monitor: pops the expected queues whenever a done pulse appears.
  always @(negedge Clk) begin
    exp_t e;
    if (vif.VMERdDone === 1'b1) begin
      if (rq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rd_done @cyc %0d: got pulse expected none", cyc);
      end else begin
        e = rq.pop_front();
        chk("rd_data", vif.VMERdData, e.d);
        chk("rd_latency", 32'(cyc), 32'(e.due));
      end
    end else if (rq.size() > 0 && rq[0].due < cyc) begin
      n_vec++; n_err++;
      $display("FAIL rd_done @cyc %0d: got none expected pulse due %0d", cyc, rq[0].due);
      void'(rq.pop_front());
    end
    if (vif.VMEWrDone === 1'b1) begin
      if (wq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wr_done @cyc %0d: got pulse expected none", cyc);
      end else begin
        e = wq.pop_front();
        chk("wr_latency", 32'(cyc), 32'(e.due));
      end
    end else if (wq.size() > 0 && wq[0].due < cyc) begin
      n_vec++; n_err++;
      $display("FAIL wr_done @cyc %0d: got none expected pulse due %0d", cyc, wq[0].due);
      void'(wq.pop_front());
    end
  end

  // Shorthands
  task automatic idle();                        cycle(0,0,0,0,0,0,0); endtask
  task automatic rd_st();                       cycle(0,1,0,0,0,0,0); endtask
  task automatic pop_d();                       cycle(0,1,0,1,0,0,0); endtask
  task automatic wr_st(input logic [31:0] v);   cycle(0,0,1,0,v,0,0); endtask
  task automatic stream(input logic [31:0] v);  cycle(0,0,0,0,0,1,v); endtask

  initial begin
    bit rd, wr, addr, sv;
    logic [31:0] wd;
    int r;
    Rst = 1'b1;
    vif.VMERdMem = 0; vif.VMEWrMem = 0; vif.VMEAddr = 0; vif.VMEWrData = 0;
    fifo_wr_valid_i = 0; fifo_wr_data_i = 0;

    // Reset, with a strobe and a stream word that must both be discarded
    cycle(1,0,0,0,0,0,0);
    cycle(1,1,0,1,0,1,32'hDEAD);
    cycle(1,0,1,1,32'h1234,0,0);
    rd_st();                                  // expect 0x00010000
    idle();

    // Three streamed words popped back-to-back
    for (int i = 0; i < 3; i++) stream(32'hA0 + i);
    repeat (3) pop_d();
    rd_st();

    // Fill, refused stream word, overflow, sticky clear
    for (int i = 0; i < DEPTH; i++) stream(32'h100 + i);
    stream(32'hBAD);
    cycle(0,0,1,1,32'h55,0,0);
    rd_st();                                  // expect 0x00060010
    wr_st(32'h2);
    rd_st();                                  // expect 0x00020010

    // Clear, underflow, then underflowing pop together with a push
    wr_st(32'h1);
    pop_d();
    cycle(0,1,0,1,0,1,32'hC0);
    rd_st();
    pop_d();
    rd_st();

    // Continuous stream with a bus DATA write in the middle
    for (int i = 0; i < 8; i++) cycle(0,0,(i == 3),1,32'h77,1,32'hD0 + i);
    repeat (10) pop_d();
    wr_st(32'h2);

    // Wrap-around: 40 words pushed and popped interleaved
    for (int i = 0; i < 40; i++) cycle(0,(i > 0),0,1,0,1,32'hE00 + i);
    pop_d();
    rd_st();
    for (int i = 0; i < 5; i++) stream(32'hF0 + i);
    wr_st(32'h1);
    rd_st();                                  // count 0

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r    = $urandom_range(0, 99);
      rd   = (r < 30) || (r >= 95);
      wr   = (r >= 30 && r < 45) || (r >= 95);
      addr = $urandom_range(0, 1) != 0;
      wd   = $urandom;
      if (!addr && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      sv   = $urandom_range(0, 2) != 0;
      cycle((r == 50 && $urandom_range(0, 3) == 0), rd, wr, addr, wd, sv, $urandom);
    end

    repeat (4) idle();
    chk("drain", 32'(rq.size() + wq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
